// File: rtl/seq1001_pkg.sv
// Shared definitions for the 1001-sync serial framing: transmitter state
// encoding and the sync word, reused by the matching detector and benches.
package seq1001_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam logic [3:0] SYNC_WORD = 4'b1001;
  localparam int         SYNC_BITS = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq1001_tx.sv
// Serial frame transmitter: sync word 1001, DATA_W payload bits MSB first,
// then GAP_BITS idle zeros. One payload word accepted per frame.
module seq1001_tx
  import seq1001_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              din_ready,
  output logic              dout,
  output logic              frame_done
);

  localparam int CNT_MAX = max3(SYNC_BITS, DATA_W, GAP_BITS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_BITS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              dout_d;
  logic              frame_done_d;
  logic              hs;

  assign din_ready = (state_q == IDLE);
  assign hs        = din_valid && din_ready;

  // Next state: the counter holds the bits still to send in the current
  // state after this one, so zero marks the last cycle of that state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = SYNC;
          cnt_d   = SYNC_LOAD;
          shreg_d = din;
        end
      end
      SYNC: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = DATA_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        shreg_d = shreg_q << 1;
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so dout leaves a flop aligned
  // with the state it belongs to.
  always_comb begin
    dout_d       = 1'b0;
    frame_done_d = 1'b0;
    case (state_d)
      SYNC: dout_d = SYNC_WORD[cnt_d[1:0]];
      DATA: begin
        dout_d       = shreg_d[DATA_W-1];
        frame_done_d = (cnt_d == '0);
      end
      default: begin
        dout_d       = 1'b0;
        frame_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      dout       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      dout       <= dout_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_seq1001_tx.sv
// Bench for seq1001_tx: per-cycle scoreboard of dout/frame_done/din_ready
// plus a loopback 1001 detector, and directed scenario tasks.
module tb_seq1001_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_ready, dout, frame_done;

  logic       b_valid = 1'b0;
  logic [0:0] b_din = 1'b0;
  logic       b_ready, b_dout, b_fd;

  always #5 clk = ~clk;

  seq1001_tx #(.DATA_W(8), .GAP_BITS(2)) dut (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .dout(dout), .frame_done(frame_done)
  );

  seq1001_tx #(.DATA_W(1), .GAP_BITS(1)) dut_min (
    .clk(clk), .reset(reset), .din_valid(b_valid), .din(b_din),
    .din_ready(b_ready), .dout(b_dout), .frame_done(b_fd)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic d;
    logic fd;
    logic s4;
  } exp_t;

  exp_t       exp_q[$];
  bit         model_rdy = 1'b1;
  bit         det_en = 1'b0;
  int         dst = 0;
  int         det_cnt = 0;
  logic [3:0] sync_word = 4'b1001;

  // Model: a handshake happens when the model is idle and din_valid is high;
  // it schedules 4 sync + 8 payload + 2 gap cycles, then one idle cycle.
  initial forever begin
    exp_t e;
    @(posedge clk);
    if (reset === 1'b1 && din_valid === 1'b1 && model_rdy) begin
      for (int i = 3; i >= 0; i--) begin
        e.d = sync_word[i]; e.fd = 1'b0; e.s4 = (i == 0);
        exp_q.push_back(e);
      end
      for (int i = 7; i >= 0; i--) begin
        e.d = din[i]; e.fd = (i == 0); e.s4 = 1'b0;
        exp_q.push_back(e);
      end
      for (int i = 0; i < 2; i++) begin
        e = '0;
        exp_q.push_back(e);
      end
    end
  end

  initial forever begin
    exp_t e;
    bit   hit;
    @(negedge clk);
    if (reset !== 1'b1) begin
      exp_q.delete();
      model_rdy = 1'b1;
      dst = 0;
      tests++;
      if (dout !== 1'b0) begin fails++; $display("FAIL sb_reset_dout: got %b expected 0", dout); end
      tests++;
      if (frame_done !== 1'b0) begin fails++; $display("FAIL sb_reset_fd: got %b expected 0", frame_done); end
      tests++;
      if (din_ready !== 1'b1) begin fails++; $display("FAIL sb_reset_ready: got %b expected 1", din_ready); end
    end else begin
      model_rdy = (exp_q.size() == 0);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = '0;
      tests++;
      if (dout !== e.d) begin fails++; $display("FAIL sb_dout: got %b expected %b at %0t", dout, e.d, $time); end
      tests++;
      if (frame_done !== e.fd) begin fails++; $display("FAIL sb_frame_done: got %b expected %b at %0t", frame_done, e.fd, $time); end
      tests++;
      if (din_ready !== model_rdy) begin fails++; $display("FAIL sb_din_ready: got %b expected %b at %0t", din_ready, model_rdy, $time); end
      if (det_en) begin
        hit = (dst == 3) && (dout === 1'b1);
        tests++;
        if (hit !== e.s4) begin fails++; $display("FAIL sb_detect: got %b expected %b at %0t", hit, e.s4, $time); end
        if (hit) begin
          dst = 0;
          det_cnt++;
        end else if (dout === 1'b1) dst = 1;
        else if (dst == 1) dst = 2;
        else if (dst == 2) dst = 3;
        else dst = 0;
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit hold);
    int n = 0;
    @(negedge clk);
    din = d;
    din_valid = 1'b1;
    while (din_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      tests++; fails++;
      $display("FAIL send_timeout: got ready=%b expected 1 within 64 cycles", din_ready);
    end
    @(posedge clk);
    #1;
    if (!hold) din_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if (dout !== 1'b0) begin fails++; $display("FAIL reset_dout: got %b expected 0", dout); end
    tests++;
    if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
    tests++;
    if (din_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", din_ready); end
    tests++;
    if (b_ready !== 1'b1 || b_dout !== 1'b0) begin fails++; $display("FAIL reset_min: got ready=%b dout=%b expected 1/0", b_ready, b_dout); end
    // First rising edge after release must already accept a word.
    @(negedge clk);
    #1;
    reset = 1'b1;
    din = 8'hA5;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    tests++;
    if (dout !== 1'b1) begin fails++; $display("FAIL first_edge_sync: got %b expected 1", dout); end
    tests++;
    if (din_ready !== 1'b0) begin fails++; $display("FAIL first_edge_busy: got %b expected 0", din_ready); end
    repeat (16) @(negedge clk);
  endtask

  task automatic test_a5();
    logic [13:0] exp_bits = 14'b10011010010100;
    send(8'hA5, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      tests++;
      if (dout !== exp_bits[14-k]) begin fails++; $display("FAIL a5_bit%0d: got %b expected %b", k, dout, exp_bits[14-k]); end
      tests++;
      if (frame_done !== (k == 12)) begin fails++; $display("FAIL a5_fd%0d: got %b expected %b", k, frame_done, (k == 12)); end
    end
    tests++;
    if (din_ready !== 1'b0) begin fails++; $display("FAIL a5_ready14: got %b expected 0", din_ready); end
    @(negedge clk);
    tests++;
    if (din_ready !== 1'b1) begin fails++; $display("FAIL a5_ready15: got %b expected 1", din_ready); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int fd1 = -1;
    int fd2 = -1;
    int nfd = 0;
    @(negedge clk);
    din = 8'hFF;
    din_valid = 1'b1;
    while (din_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin tests++; fails++; $display("FAIL b2b_timeout: got ready=%b expected 1", din_ready); end
    @(posedge clk);
    #1;
    din = 8'h00;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        nfd++;
        if (fd1 < 0) fd1 = k;
        else if (fd2 < 0) fd2 = k;
      end
      if (k >= 16 && k <= 19) begin
        tests++;
        if (dout !== sync_word[19-k]) begin fails++; $display("FAIL b2b_sync%0d: got %b expected %b", k, dout, sync_word[19-k]); end
      end
      if (k >= 20 && k <= 27) begin
        tests++;
        if (dout !== 1'b0) begin fails++; $display("FAIL b2b_payload%0d: got %b expected 0", k, dout); end
      end
      if (k == 20) din_valid = 1'b0;
    end
    tests++;
    if (fd1 != 12) begin fails++; $display("FAIL b2b_fd1: got %0d expected 12", fd1); end
    tests++;
    if (fd2 - fd1 != 15) begin fails++; $display("FAIL b2b_period: got %0d expected 15", fd2 - fd1); end
    tests++;
    if (nfd != 2) begin fails++; $display("FAIL b2b_frames: got %0d expected 2", nfd); end
  endtask

  task automatic test_din_change();
    int n = 0;
    logic [7:0] got = '0;
    @(negedge clk);
    din = 8'h3C;
    din_valid = 1'b1;
    while (din_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin tests++; fails++; $display("FAIL chg_timeout: got ready=%b expected 1", din_ready); end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din = 8'hC3;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k >= 5) got = {got[6:0], dout};
    end
    tests++;
    if (got !== 8'h3C) begin fails++; $display("FAIL din_change: got %h expected 3c", got); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    send(8'hFF, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (dout !== 1'b1) begin fails++; $display("FAIL mid_bit6: got %b expected 1", dout); end
    reset = 1'b0;
    #1;
    tests++;
    if (dout !== 1'b0) begin fails++; $display("FAIL mid_async_dout: got %b expected 0", dout); end
    tests++;
    if (frame_done !== 1'b0 || din_ready !== 1'b1) begin fails++; $display("FAIL mid_async_ctl: got fd=%b ready=%b expected 0/1", frame_done, din_ready); end
    @(negedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (dout !== 1'b0) begin fails++; $display("FAIL mid_resume%0d: got %b expected 0", k, dout); end
    end
    send(8'h00, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests++;
      if (dout !== sync_word[4-k]) begin fails++; $display("FAIL mid_restart%0d: got %b expected %b", k, dout, sync_word[4-k]); end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_min_params();
    logic [5:0] exp_bits = 6'b100110;
    @(negedge clk);
    b_din = 1'b1;
    b_valid = 1'b1;
    tests++;
    if (b_ready !== 1'b1) begin fails++; $display("FAIL min_ready0: got %b expected 1", b_ready); end
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 6) begin
        tests++;
        if (b_dout !== exp_bits[6-k]) begin fails++; $display("FAIL min_bit%0d: got %b expected %b", k, b_dout, exp_bits[6-k]); end
        tests++;
        if (b_fd !== (k == 5)) begin fails++; $display("FAIL min_fd%0d: got %b expected %b", k, b_fd, (k == 5)); end
        tests++;
        if (b_ready !== 1'b0) begin fails++; $display("FAIL min_busy%0d: got %b expected 0", k, b_ready); end
      end else begin
        tests++;
        if (b_ready !== 1'b1) begin fails++; $display("FAIL min_ready7: got %b expected 1", b_ready); end
      end
    end
  endtask

  task automatic test_loopback();
    logic [7:0] p;
    bit ok;
    dst = 0;
    det_cnt = 0;
    det_en = 1'b1;
    for (int f = 0; f < 100; f++) begin
      do begin
        p = 8'($urandom_range(0, 255));
        ok = 1'b1;
        for (int i = 0; i <= 4; i++) if (p[i +: 4] == 4'b1001) ok = 1'b0;
      end while (!ok);
      send(p, 1'b0);
    end
    repeat (16) @(negedge clk);
    tests++;
    if (det_cnt != 100) begin fails++; $display("FAIL loopback_count: got %0d expected 100", det_cnt); end
    det_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    test_reset();
    test_a5();
    test_back_to_back();
    test_din_change();
    test_reset_mid();
    test_min_params();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq1001_tx.md
SEQ1001_TX -- requirements
Module: seq1001_tx

Interface
- REQ-001 Parameter DATA_W, default 8: payload width in bits; legal range 1..32.
- REQ-002 Parameter GAP_BITS, default 2: idle zero bits after each frame; legal range 1..15.
- REQ-003 clk  input  1  single clock; all state updates on its rising edge.
- REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
- REQ-005 din_valid  input  1  payload word offered this cycle.
- REQ-006 din  input  DATA_W  payload word; sampled only on handshake.
- REQ-007 din_ready  output  1  block can accept a payload this cycle.
- REQ-008 dout  output  1  serial line, registered, idle level 0.
- REQ-009 frame_done  output  1  one-cycle pulse while the last payload bit is on dout.

Function
- REQ-010 Handshake SHALL occur in any cycle with din_valid=1 and din_ready=1; din SHALL be captured into the shift register on that edge.
- REQ-011 din_ready SHALL equal 1 only in state IDLE; din_valid while busy SHALL be ignored, with no queuing.
- REQ-012 FSM states SHALL be IDLE, SYNC, DATA, GAP.
- REQ-013 IDLE -> SYNC on handshake. SYNC -> DATA after 4 bits. DATA -> GAP after DATA_W bits. GAP -> IDLE after GAP_BITS bits.
- REQ-014 In SYNC, dout SHALL drive the sync word 1,0,0,1 on four consecutive cycles, starting the cycle after handshake.
- REQ-015 In DATA, dout SHALL drive the captured payload MSB first, one bit per cycle.
- REQ-016 In IDLE and GAP, dout SHALL be 0.
- REQ-017 frame_done SHALL be 1 exactly in the cycle dout carries payload bit 0, and 0 otherwise.
- REQ-018 Latency: first sync bit appears 1 cycle after handshake; din_ready reasserts 4+DATA_W+GAP_BITS+1 cycles after handshake.
- REQ-019 Minimum frame period SHALL be 5+DATA_W+GAP_BITS cycles (15 at default parameters).
- REQ-020 Changes on din after handshake SHALL NOT affect the frame in flight.
- REQ-021 A single bit counter SHALL be shared across SYNC/DATA/GAP, reloaded on each state entry, width $clog2 of max(4, DATA_W, GAP_BITS)+1.
- REQ-022 Illegal or unreachable state encodings SHALL return to IDLE on the next edge, with dout=0.

Reset
- REQ-023 While reset=0: state=IDLE, dout=0, frame_done=0, counter=0, shift register=0; din_ready reads 1.
- REQ-024 Reset asserted mid-frame SHALL force dout=0 immediately (asynchronous) and abandon the frame; no partial frame resumes after release.
- REQ-025 The first handshake SHALL be possible in the first rising edge with reset=1.

Structure
- REQ-026 Shared package seq1001_pkg SHALL hold the state typedef (IDLE, SYNC, DATA, GAP) and the constant SYNC_WORD=4'b1001, for reuse by the matching detector and by benches.
- REQ-027 No sub-module; FSM, counter and PISO shift register are inline in seq1001_tx.

Verification
- REQ-028 Handshake with din=8'hA5 -> dout from the next cycle is 1,0,0,1,1,0,1,0,0,1,0,1,0,0; frame_done high on the 12th bit; din_ready high 15 cycles after handshake.
- REQ-029 din_valid held at 1 with din=8'hFF then 8'h00 -> two frames 15 cycles apart; the second frame's payload is all 0, with no bits dropped or duplicated.
- REQ-030 Reset pulled low on the 6th bit of a frame -> dout=0 in the same cycle; after release din_ready=1 and the next frame starts clean with 1,0,0,1.
- REQ-031 din changed from 8'h3C to 8'hC3 one cycle after handshake -> the payload transmitted is 0,0,1,1,1,1,0,0.
- REQ-032 Loopback into a non-overlapping 1001 Mealy detector, with 100 random payloads whose bits avoid 1001 -> exactly one detect per frame, coincident with the 4th sync bit.
- REQ-033 DATA_W=1, GAP_BITS=1, din=1'b1 -> dout 1,0,0,1,1,0; frame_done on the 5th bit; din_ready returns 7 cycles after handshake.
